multicycle_control: RTL and testbench

//  Moore FSM sequencing the multi-cycle MIPS datapath around the instruction memory/decoder.

---
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multi-cycle MIPS datapath.
// Optional: define ILLEGAL_TRAP_EN to trap illegal opcodes (adds port illegal).
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
`ifdef ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JR        = 4'd12,
        S_TRAP      = 4'd13,
        S_START     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_q;
    state_t state_d;
    logic [CNT_W-1:0] count_q;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_START;
        else       state_q <= state_d;
    end

    // Retired-instruction counter: one tick per completed fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else if (state_q == S_FETCH && mem_ready)
            count_q <= count_q + 1'b1;
    end

    // Next-state logic and Moore strobes (fetch strobes gated by mem_ready).
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
`ifdef ILLEGAL_TRAP_EN
        illegal       = 1'b0;
`endif
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_RTYPE:
                        state_d = (funct == FN_JR) ? S_JR : S_R_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
                state_d  = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            // Sticky until reset.
            S_TRAP: illegal = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: random instruction mix
// against a per-instruction state-path reference model.
module tb_multicycle_control;

    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic mem_ready = 1'b0;
    logic pc_write, pc_write_cond, ir_write, i_or_d;
    logic mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;
    logic [CW-1:0] instr_count;
`ifdef ILLEGAL_TRAP_EN
    logic illegal;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
`ifdef ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .state(state), .instr_count(instr_count)
    );

    typedef struct packed {
        logic pcw, pcwc;
        logic [1:0] pcs;
        logic irw, iod, memrd, memwr, m2r, rdst, rw, asa;
        logic [1:0] asb, aop;
    } outs_t;

    typedef struct {
        int st;
        outs_t o;
        logic il;
        logic [CW-1:0] cnt;
    } exp_t;

    outs_t act;
    assign act = {pc_write, pc_write_cond, pc_src, ir_write, i_or_d,
                  mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                  alu_src_a, alu_src_b, alu_op};

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    logic [CW-1:0] mcount = '0;

    // Strobe table of the datapath, one row per state.
    function automatic outs_t exp_out(int st, logic rdy);
        outs_t o = '0;
        case (st)
            0: begin o.memrd = 1; o.asb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            1: o.asb = 2'b11;
            2: begin o.asa = 1; o.asb = 2'b10; end
            3: begin o.memrd = 1; o.iod = 1; end
            4: begin o.rw = 1; o.m2r = 1; end
            5: begin o.memwr = 1; o.iod = 1; end
            6: begin o.asa = 1; o.aop = 2'b10; end
            7: begin o.rw = 1; o.rdst = 1; end
            8: begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; end
            9: begin o.pcw = 1; o.pcs = 2'b10; end
            10: begin o.asa = 1; o.asb = 2'b10; end
            11: o.rw = 1;
            12: begin o.pcw = 1; o.pcs = 2'b11; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(string name, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, a, e, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a state, check the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("outs", 32'(act), 32'(e.o));
            chk("count", 32'(instr_count), 32'(e.cnt));
`ifdef ILLEGAL_TRAP_EN
            chk("illegal", 32'(illegal), 32'(e.il));
`endif
        end
    end

    // One cycle: drive inputs, predict what the DUT shows this cycle.
    task automatic step(int st, logic rdy, logic [5:0] op, logic [5:0] fn);
        exp_t e;
        mem_ready = rdy;
        opcode = op;
        funct = fn;
        e.st = st;
        e.o = exp_out(st, rdy);
        e.il = (st == 13);
        e.cnt = mcount;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (st == 0 && rdy) mcount = mcount + 1'b1;
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom);
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op == 6'h23 || op == 6'h2B || op == 6'h00 ||
               op == 6'h04 || op == 6'h02 || op == 6'h08;
    endfunction

    // kinds: 0 lw, 1 sw, 2 R, 3 addi, 4 beq, 5 j, 6 jr, 7 illegal
    task automatic get_code(int k, output logic [5:0] op, output logic [5:0] fn);
        fn = rnd6();
        case (k)
            0: op = 6'h23;
            1: op = 6'h2B;
            2: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
            3: op = 6'h08;
            4: op = 6'h04;
            5: op = 6'h02;
            6: begin op = 6'h00; fn = 6'h08; end
            default: begin
                op = rnd6();
                while (is_legal(op)) op = rnd6();
            end
        endcase
    endtask

    task automatic mem_wait(int st, int w);
        for (int i = 0; i < w; i++) step(st, 1'b0, rnd6(), rnd6());
        step(st, 1'b1, rnd6(), rnd6());
    endtask

    task automatic fetch_decode(int fw, logic [5:0] op, logic [5:0] fn);
        mem_wait(0, fw);
        step(1, 1'($urandom), op, fn);
    endtask

    task automatic run_instr(int k, int fw, int mw);
        logic [5:0] op, fn;
        get_code(k, op, fn);
        fetch_decode(fw, op, fn);
        case (k)
            0: begin step(2, 1'($urandom), op, fn); mem_wait(3, mw);
                     step(4, 1'($urandom), rnd6(), rnd6()); end
            1: begin step(2, 1'($urandom), op, fn); mem_wait(5, mw); end
            2: begin step(6, 1'($urandom), rnd6(), rnd6());
                     step(7, 1'($urandom), rnd6(), rnd6()); end
            3: begin step(10, 1'($urandom), rnd6(), rnd6());
                     step(11, 1'($urandom), rnd6(), rnd6()); end
            4: step(8, 1'($urandom), rnd6(), rnd6());
            5: step(9, 1'($urandom), rnd6(), rnd6());
            6: step(12, 1'($urandom), rnd6(), rnd6());
            default: ;
        endcase
    endtask

    // Assert reset at the current point, check it clears at once, then release.
    task automatic reset_seq();
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'hF);
        chk("rst_outs", 32'(act), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h0);
`ifdef ILLEGAL_TRAP_EN
        chk("rst_illegal", 32'(illegal), 32'h0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        mcount = '0;
        step(15, 1'($urandom), rnd6(), rnd6());
    endtask

    initial begin
        #1;
        reset_seq();
        // Directed: fetch, lw with memory stall, the ALU/branch mix, sw.
        run_instr(0, 0, 3);
        run_instr(2, 0, 0);
        run_instr(3, 0, 0);
        run_instr(4, 0, 0);
        run_instr(5, 0, 0);
        run_instr(6, 0, 0);
        run_instr(1, 2, 2);
        // Randomized mix with random fetch and data stalls.
        for (int n = 0; n < 200; n++) begin
`ifdef ILLEGAL_TRAP_EN
            run_instr($urandom_range(0, 6), $urandom_range(0, 2),
                      $urandom_range(0, 3));
`else
            run_instr($urandom_range(0, 7), $urandom_range(0, 2),
                      $urandom_range(0, 3));
`endif
        end
        // Illegal opcode.
`ifdef ILLEGAL_TRAP_EN
        fetch_decode(0, 6'h3F, rnd6());
        for (int i = 0; i < 10; i++) step(13, 1'($urandom), rnd6(), rnd6());
        reset_seq();
`else
        run_instr(7, 0, 0);
        fetch_decode(0, 6'h3F, rnd6());
`endif
        // Reset while in R_WB: strobes drop immediately.
        fetch_decode(0, 6'h00, 6'h20);
        step(6, 1'b1, rnd6(), rnd6());
        reset_seq();
        // Counter wrap.
        for (int i = 0; i < (1 << CW) - 1; i++) run_instr(5, 0, 0);
        chk("pre_wrap", 32'(instr_count), 32'((1 << CW) - 1));
        run_instr(5, 0, 0);
        chk("wrap", 32'(instr_count), 32'h0);
        @(negedge clk);
        #1;
        chk("drain", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
